// File: rtl/big_split_pkg.sv
// big_split_pkg: shared constants, destination enum and the steering decode
// for the big_split router stage.
package big_split_pkg;

  localparam int W         = 11;           // packet data width
  localparam int CW        = 2;            // network port-select width
  localparam int NUM_NET   = 4;            // network outputs (2**CW)
  localparam int NUM_SLOTS = NUM_NET + 1;  // network outputs plus core

  // Encoding doubles as the slot index: out1..out4 are 0..3, core is 4.
  typedef enum logic [2:0] {
    DEST_OUT1 = 3'd0,
    DEST_OUT2 = 3'd1,
    DEST_OUT3 = 3'd2,
    DEST_OUT4 = 3'd3,
    DEST_CORE = 3'd4
  } dest_t;

  // The port select is still present when routing to the core; it is ignored.
  function automatic dest_t decode_dest(input logic core_ctrl, input logic [CW-1:0] ctrl);
    if (core_ctrl) return DEST_CORE;
    return dest_t'({1'b0, ctrl});
  endfunction

endpackage

// File: rtl/big_split_slot.sv
// big_split_slot: one-entry output register with a valid/ready drain side.
//   clk_i, rst_ni  clock, async active-low reset
//   load_i, data_i write a new token (must only be asserted when can_load_o)
//   ready_i        consumer ready
//   valid_o        slot FULL
//   data_o         registered slot contents, stable while FULL
//   can_load_o     EMPTY, or FULL and draining this cycle (pass-through refill)
module big_split_slot
  import big_split_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         can_load_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign can_load_o = !full_q || ready_i;
  assign valid_o    = full_q;
  assign data_o     = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/big_split.sv
// big_split: router split stage. Joins a packet token, a network port-select
// token and a core-select token, then steers the packet into one of five
// one-entry output slots (core, out1..out4).
//   CLK, _RESET                      clock, async active-low reset
//   in_data/in_valid/in_ready        packet channel
//   ctrl_data/ctrl_valid/ctrl_ready  network port select (00 -> out1 .. 11 -> out4)
//   core_ctrl/core_ctrl_valid/_ready 1 = core, 0 = network
//   core_out_*                       local core output
//   outN_*                           network outputs, N = 1..4
module big_split
  import big_split_pkg::*;
(
  input  logic          CLK,
  input  logic          _RESET,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] ctrl_data,
  input  logic          ctrl_valid,
  output logic          ctrl_ready,
  input  logic          core_ctrl,
  input  logic          core_ctrl_valid,
  output logic          core_ctrl_ready,
  output logic [W-1:0]  core_out_data,
  output logic          core_out_valid,
  input  logic          core_out_ready,
  output logic [W-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [W-1:0]  out2_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [W-1:0]  out3_data,
  output logic          out3_valid,
  input  logic          out3_ready,
  output logic [W-1:0]  out4_data,
  output logic          out4_valid,
  input  logic          out4_ready
);

  logic [NUM_SLOTS-1:0]        slot_ready, slot_valid, slot_can_load, slot_load, dest_oh;
  logic [NUM_SLOTS-1:0][W-1:0] slot_data;
  dest_t                       dest;
  logic                        join_ok;

  assign slot_ready = {core_out_ready, out4_ready, out3_ready, out2_ready, out1_ready};

  assign dest    = decode_dest(core_ctrl, ctrl_data);
  assign dest_oh = NUM_SLOTS'(1) << dest;

  // Only the addressed slot gates the join, so a stalled output never blocks
  // traffic headed elsewhere. Reset masks the readies so nothing is consumed
  // while _RESET is low.
  assign join_ok = _RESET && in_valid && ctrl_valid && core_ctrl_valid
                   && |(dest_oh & slot_can_load);

  assign slot_load = join_ok ? dest_oh : '0;

  assign in_ready        = join_ok;
  assign ctrl_ready      = join_ok;
  assign core_ctrl_ready = join_ok;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    big_split_slot u_slot (
      .clk_i      (CLK),
      .rst_ni     (_RESET),
      .load_i     (slot_load[i]),
      .data_i     (in_data),
      .ready_i    (slot_ready[i]),
      .valid_o    (slot_valid[i]),
      .data_o     (slot_data[i]),
      .can_load_o (slot_can_load[i])
    );
  end

  assign out1_valid     = slot_valid[0];
  assign out2_valid     = slot_valid[1];
  assign out3_valid     = slot_valid[2];
  assign out4_valid     = slot_valid[3];
  assign core_out_valid = slot_valid[4];
  assign out1_data      = slot_data[0];
  assign out2_data      = slot_data[1];
  assign out3_data      = slot_data[2];
  assign out4_data      = slot_data[3];
  assign core_out_data  = slot_data[4];

endmodule

// File: tb/tb_big_split.sv
module tb_big_split;

  logic        CLK = 1'b0;
  logic        _RESET;
  logic [10:0] in_data;
  logic        in_valid, in_ready;
  logic [1:0]  ctrl_data;
  logic        ctrl_valid, ctrl_ready;
  logic        core_ctrl, core_ctrl_valid, core_ctrl_ready;
  logic [10:0] core_out_data, out1_data, out2_data, out3_data, out4_data;
  logic        core_out_valid, out1_valid, out2_valid, out3_valid, out4_valid;
  logic [4:0]  ordy; // {core, out4, out3, out2, out1}

  int checks = 0;
  int errors = 0;

  // Reference: each output is a box holding at most one packet.
  bit        m_full [5];
  bit [10:0] m_data [5];

  always #5 CLK = ~CLK;

  big_split dut (
    .CLK(CLK), ._RESET(_RESET),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .core_ctrl(core_ctrl), .core_ctrl_valid(core_ctrl_valid), .core_ctrl_ready(core_ctrl_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(ordy[4]),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(ordy[0]),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(ordy[1]),
    .out3_data(out3_data), .out3_valid(out3_valid), .out3_ready(ordy[2]),
    .out4_data(out4_data), .out4_valid(out4_valid), .out4_ready(ordy[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic obs_valid(input int i);
    case (i)
      0: return out1_valid;
      1: return out2_valid;
      2: return out3_valid;
      3: return out4_valid;
      default: return core_out_valid;
    endcase
  endfunction

  function automatic logic [10:0] obs_data(input int i);
    case (i)
      0: return out1_data;
      1: return out2_data;
      2: return out3_data;
      3: return out4_data;
      default: return core_out_data;
    endcase
  endfunction

  function automatic int target();
    return core_ctrl ? 4 : int'(ctrl_data);
  endfunction

  function automatic bit exp_accept();
    int t = target();
    return in_valid && ctrl_valid && core_ctrl_valid && (!m_full[t] || ordy[t]);
  endfunction

  task automatic model_reset();
    foreach (m_full[i]) begin m_full[i] = 0; m_data[i] = '0; end
  endtask

  task automatic drive(input bit iv, cv, ccv, input logic [10:0] d, input logic [1:0] c,
                       input bit cc, input logic [4:0] r);
    in_valid = iv; ctrl_valid = cv; core_ctrl_valid = ccv;
    in_data = d; ctrl_data = c; core_ctrl = cc; ordy = r;
  endtask

  // Called just after a falling edge with inputs driven: checks readies and
  // outputs against the model, then advances the model across the rising edge.
  task automatic cyc(input bit iv, cv, ccv, input logic [10:0] d, input logic [1:0] c,
                     input bit cc, input logic [4:0] r);
    bit acc;
    int t;
    drive(iv, cv, ccv, d, c, cc, r);
    #1;
    acc = exp_accept();
    t   = target();
    chk("in_ready", in_ready, acc);
    chk("ctrl_ready", ctrl_ready, acc);
    chk("core_ctrl_ready", core_ctrl_ready, acc);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("valid%0d", i), obs_valid(i), m_full[i]);
      if (m_full[i]) chk($sformatf("data%0d", i), obs_data(i), m_data[i]);
    end
    @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      if (acc && i == t) begin m_full[i] = 1; m_data[i] = d; end
      else if (ordy[i]) m_full[i] = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    _RESET = 1'b0;
    model_reset();
    drive(1, 1, 1, 11'h7ff, 2'd0, 0, 5'h1f);
    repeat (2) @(negedge CLK);
    #1;
    // Reset state, with all valids high: nothing may be accepted.
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl_ready", ctrl_ready, 0);
    chk("rst_core_ctrl_ready", core_ctrl_ready, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_valid%0d", i), obs_valid(i), 0);
      chk($sformatf("rst_data%0d", i), obs_data(i), 0);
    end
    @(negedge CLK);
    _RESET = 1'b1;

    // Core delivery: ctrl value is ignored.
    cyc(1, 1, 1, 11'd5, 2'b10, 1, 5'h1f);
    chk("core_valid", core_out_valid, 1);
    chk("core_data", core_out_data, 11'd5);
    chk("net_valids_idle", {out4_valid, out3_valid, out2_valid, out1_valid}, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'h1f);

    // Network stream 1..8, one per cycle.
    for (int k = 1; k <= 8; k++) cyc(1, 1, 1, 11'(k), 2'(k), 0, 5'h1f);
    cyc(0, 0, 0, 0, 0, 0, 5'h1f);

    // Backpressure on out3; out1 proceeds around it.
    cyc(1, 1, 1, 11'd7, 2'd2, 0, 5'b11011);
    cyc(1, 1, 1, 11'd8, 2'd2, 0, 5'b11011);
    chk("stall_ready", in_ready, 0);
    cyc(1, 1, 1, 11'd9, 2'd0, 0, 5'b11011);
    chk("out3_held", out3_data, 11'd7);
    cyc(1, 1, 1, 11'd8, 2'd2, 0, 5'h1f);   // drain 7 and refill with 8
    chk("out3_refill", out3_data, 11'd8);
    cyc(0, 0, 0, 0, 0, 0, 5'h1f);

    // Partial join: core_ctrl token missing for 5 cycles.
    repeat (5) cyc(1, 1, 0, 11'd33, 2'd1, 0, 5'h1f);
    cyc(1, 1, 1, 11'd33, 2'd1, 0, 5'h1f);
    chk("partial_then_out2", out2_data, 11'd33);
    cyc(0, 0, 0, 0, 0, 0, 5'h1f);

    // Pass-through refill on out4.
    cyc(1, 1, 1, 11'd99, 2'd3, 0, 5'h1f);
    cyc(1, 1, 1, 11'd100, 2'd3, 0, 5'h1f);
    chk("out4_no_bubble", {21'd0, out4_valid, out4_data}, {21'd0, 1'b1, 11'd100});
    cyc(0, 0, 0, 0, 0, 0, 5'h1f);

    // Reset mid-operation with out1 holding 42.
    cyc(1, 1, 1, 11'd42, 2'd0, 0, 5'b11110);
    drive(0, 0, 0, 0, 0, 0, 5'b11110);
    #2 _RESET = 1'b0;
    #1;
    chk("mid_rst_out1_valid", out1_valid, 0);
    chk("mid_rst_out1_data", out1_data, 0);
    model_reset();
    #1 _RESET = 1'b1;
    @(negedge CLK);
    cyc(1, 1, 1, 11'd17, 2'd0, 0, 5'h1f);
    chk("post_rst_out1", out1_data, 11'd17);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 9) < 6);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          11'($urandom), 2'($urandom), $urandom_range(0, 4) == 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/big_split.md
Name: big_split

Overview:
- Synchronous RTL form of the NoC router "split" stage: joins one 11-bit packet token with one 2-bit port-select token and one 1-bit core-select token, then steers the packet to exactly one of five output channels.
- Outputs: the local core output, or one of four network outputs.
- Sits between the router input buffer and the output arbiters.
- Each channel is a valid/ready pair replacing a four-phase e1ofN_M channel.

Parameters:
- W, 11, packet data width (inPort, core_output, outPort1..4).
- CW, 2, port-select width; selects one of 2**CW = 4 network outputs.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- _RESET  in  1  asynchronous active-low reset.
- in_data  in  W  packet token.
- in_valid / in_ready  in / out  1 / 1  packet channel handshake.
- ctrl_data  in  CW  network-port select.
- ctrl_valid / ctrl_ready  in / out  1 / 1  port-select channel handshake.
- core_ctrl  in  1  1 = deliver to core, 0 = deliver to network.
- core_ctrl_valid / core_ctrl_ready  in / out  1 / 1  core-select channel handshake.
- core_out_data  out  W  local core output.
- core_out_valid / core_out_ready  out / in  1 / 1  core output handshake.
- outN_data  out  W  network output N, for N = 1..4.
- outN_valid / outN_ready  out / in  1 / 1  handshake for network output N, N = 1..4.

Behaviour:
- Transfer rule: a transfer occurs on a channel in a cycle where valid && ready at the rising CLK edge.
- Output slots:
  - Each of the five outputs has a one-entry slot with state EMPTY or FULL.
  - Its valid output equals FULL.
  - Its data output is registered and held stable while FULL.
- Join condition (all three required):
  - in_valid, ctrl_valid and core_ctrl_valid are all 1.
  - The target slot is EMPTY, or is FULL with its ready=1 in the same cycle (pass-through refill).
  - Target slot: core_ctrl=1 → core; core_ctrl=0 → network slot ctrl_data+1 (00→out1, 01→out2, 10→out3, 11→out4).
- Input readies:
  - in_ready, ctrl_ready and core_ctrl_ready are identical and equal the join condition.
  - All three tokens are consumed together or not at all.
  - The ctrl token is consumed even when core_ctrl=1; its value is then ignored.
- Readies are combinational from valids and slot state. No combinational path from in_data to any output data.
- Latency: the token is accepted in cycle t; the target slot is FULL with data = in_data from cycle t+1.
- Throughput: one packet per cycle when the target output is ready every cycle.
- Independent drain: slots drain independently.
  - A FULL out3 does not block packets to out1 or core.
  - Only packets targeting a FULL, not-ready slot stall.
- Slot transitions:
  - EMPTY + join → FULL.
  - FULL + ready and no new join → EMPTY.
  - FULL + ready + join → FULL, new data.
  - FULL + not ready → hold.
- Partial arrivals: if any one of the three input valids is 0, nothing is consumed, all readies are 0, and no state changes.
- Reset (_RESET=0, asynchronous, any time including mid-transfer):
  - All slots EMPTY; all *_valid = 0; all *_data = 0; all input readies = 0.
  - Pending held packets are discarded.
- Reset release: deassertion takes effect on the next CLK edge; no token is accepted in the cycle _RESET is low.
- Data width: data passes bit-exact (no sign or width change). ctrl_data is interpreted as unsigned.

Decomposition:
- Package big_split_pkg:
  - Constants W=11, CW=2, NUM_NET=4.
  - Enum dest_t {DEST_OUT1, DEST_OUT2, DEST_OUT3, DEST_OUT4, DEST_CORE}.
  - Function decoding (core_ctrl, ctrl_data) → dest_t.
- Sub-module big_split_slot: one-entry output register with load/data/ready ports, exporting valid and "can_load". Instantiated five times.
- Top level contains the join/decode logic only.

Test Plan:
- Core delivery: in_data=11'd5, ctrl=2'b10, core_ctrl=1, all outputs ready → core_out_valid=1 with data 5 one cycle later; out1..4_valid stay 0.
- Network delivery: stream 1..8 with ctrl=1,2,3,0,1,2,3,0 and core_ctrl=0 → data 1 on out2, 2 on out3, 3 on out4, 4 on out1, and so on; exactly one valid per packet; one packet per cycle.
- Backpressure: out3_ready=0, send 7 to out3, then 8 to out3 → 7 held on out3 and input readies=0 for packet 8. Meanwhile 9 to out1 in place of the stalled 8 is accepted. Raising out3_ready drains 7, then 8 next cycle.
- Partial join: in_valid=1, ctrl_valid=1, core_ctrl_valid=0 for 5 cycles → all readies 0, no output valid; core_ctrl_valid=1 → single transfer.
- Reset mid-operation: out1 FULL with 11'd42 and out1_ready=0; pulse _RESET low between clock edges → out1_valid and out1_data are 0 immediately. After release, the first new packet is delivered normally.
- Pass-through refill: out4 FULL, out4_ready=1, new packet 11'd100 to out4 in the same cycle → accepted; out4_data=100 next cycle, no bubble.
